// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access sequencer and the memory.
// Master issues one aligned beat per req/ack pair; slave holds ack low to insert waits.
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 64,
   parameter int XLEN   = 64
);
   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [XLEN-1:0]   bus_wdata;
   logic [XLEN/8-1:0] bus_wstrb;
   logic              bus_ack;
   logic [XLEN-1:0]   bus_rdata;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: splits a load/store into one or two aligned bus beats, extends load data.
// Latency: done 2 cycles after acceptance (3 if the access crosses 8 bytes) plus one per bus wait cycle.
// Backpressure: stall held from acceptance until done; bus waits by holding bus_ack low.
module mem_access_ctrl #(
   parameter int ADDR_W = 64,
   parameter int XLEN   = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic [2:0]        mem_ctrl,
   input  logic              is_store,
   input  logic [ADDR_W-1:0] addr,
   input  logic [XLEN-1:0]   wdata,
   output logic              stall,
   output logic              done,
   output logic [XLEN-1:0]   rdata,
   mem_access_ctrl_if.master bus
);
   localparam logic [2:0] MEM_BYTE       = 3'd1;
   localparam logic [2:0] MEM_BYTE_U     = 3'd2;
   localparam logic [2:0] MEM_HALFWORD   = 3'd3;
   localparam logic [2:0] MEM_HALFWORD_U = 3'd4;
   localparam logic [2:0] MEM_WORD       = 3'd5;
   localparam logic [2:0] MEM_WORD_U     = 3'd6;
   localparam logic [2:0] MEM_DWORD      = 3'd7;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BEAT0 = 2'd1;
   localparam logic [1:0] S_BEAT1 = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   function automatic logic [3:0] size_of(input logic [2:0] code);
      case (code)
         MEM_BYTE, MEM_BYTE_U:         size_of = 4'd1;
         MEM_HALFWORD, MEM_HALFWORD_U: size_of = 4'd2;
         MEM_WORD, MEM_WORD_U:         size_of = 4'd4;
         MEM_DWORD:                    size_of = 4'd8;
         default:                      size_of = 4'd0;
      endcase
   endfunction

   logic [1:0]      state;
   logic [2:0]      ctrl_q;
   logic            store_q;
   logic [2:0]      off_q;
   logic            cross_q;
   logic [XLEN-1:0] wdata_q;
   logic [XLEN-1:0] result_q;

   logic [3:0]  req_size;
   logic [2:0]  req_off;
   logic        req_ok;
   logic        req_cross;
   logic [15:0] req_mask;
   logic [15:0] lat_mask;
   logic [6:0]  hi_shift;

   always_comb begin
      req_size  = size_of(mem_ctrl);
      req_off   = addr[2:0];
      req_ok    = req_valid && (req_size != 4'd0);
      req_cross = ({1'b0, req_off} + req_size) > 4'd8;
      req_mask  = (16'd1 << req_size) - 16'd1;
      lat_mask  = (16'd1 << size_of(ctrl_q)) - 16'd1;
      // Second-beat lanes: bytes of the access that spilled past lane 7.
      hi_shift  = 7'd64 - {1'b0, off_q, 3'b000};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         ctrl_q        <= '0;
         store_q       <= 1'b0;
         off_q         <= '0;
         cross_q       <= 1'b0;
         wdata_q       <= '0;
         result_q      <= '0;
         bus.bus_req   <= 1'b0;
         bus.bus_we    <= 1'b0;
         bus.bus_addr  <= '0;
         bus.bus_wdata <= '0;
         bus.bus_wstrb <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_ok) begin
                  ctrl_q        <= mem_ctrl;
                  store_q       <= is_store;
                  off_q         <= req_off;
                  cross_q       <= req_cross;
                  wdata_q       <= wdata;
                  bus.bus_req   <= 1'b1;
                  bus.bus_we    <= is_store;
                  bus.bus_addr  <= {addr[ADDR_W-1:3], 3'b000};
                  bus.bus_wdata <= wdata << {req_off, 3'b000};
                  bus.bus_wstrb <= 8'(req_mask << req_off);
                  state         <= S_BEAT0;
               end
            end
            S_BEAT0: begin
               if (bus.bus_ack) begin
                  result_q <= bus.bus_rdata >> {off_q, 3'b000};
                  if (cross_q) begin
                     bus.bus_addr  <= bus.bus_addr + ADDR_W'(8);
                     bus.bus_wdata <= wdata_q >> hi_shift;
                     bus.bus_wstrb <= 8'(lat_mask >> (4'd8 - {1'b0, off_q}));
                     state         <= S_BEAT1;
                  end else begin
                     bus.bus_req   <= 1'b0;
                     bus.bus_we    <= 1'b0;
                     bus.bus_wdata <= '0;
                     bus.bus_wstrb <= '0;
                     state         <= S_DONE;
                  end
               end
            end
            S_BEAT1: begin
               if (bus.bus_ack) begin
                  result_q      <= result_q | (bus.bus_rdata << hi_shift);
                  bus.bus_req   <= 1'b0;
                  bus.bus_we    <= 1'b0;
                  bus.bus_wdata <= '0;
                  bus.bus_wstrb <= '0;
                  state         <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      stall = ((state == S_IDLE) && req_ok) || (state == S_BEAT0) || (state == S_BEAT1);
      done  = (state == S_DONE);
      rdata = '0;
      if ((state == S_DONE) && !store_q) begin
         case (ctrl_q)
            MEM_BYTE:       rdata = {{(XLEN-8){result_q[7]}}, result_q[7:0]};
            MEM_BYTE_U:     rdata = {{(XLEN-8){1'b0}}, result_q[7:0]};
            MEM_HALFWORD:   rdata = {{(XLEN-16){result_q[15]}}, result_q[15:0]};
            MEM_HALFWORD_U: rdata = {{(XLEN-16){1'b0}}, result_q[15:0]};
            MEM_WORD:       rdata = {{(XLEN-32){result_q[31]}}, result_q[31:0]};
            MEM_WORD_U:     rdata = {{(XLEN-32){1'b0}}, result_q[31:0]};
            MEM_DWORD:      rdata = result_q;
            default:        rdata = '0;
         endcase
      end
   end
endmodule
